// File: rtl/gbuff_pkg.sv
// Shared constants and FSM state type for the global-buffer stream reader.
package gbuff_pkg;

  localparam int unsigned ADDR_BITS_DEF = 8;
  localparam int unsigned DATA_BITS_DEF = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } gbuff_state_e;

endpackage

// File: rtl/gbuff_stream_reader_if.sv
// Valid/ready word stream from the global-buffer reader to the PE-array feeder.
interface gbuff_stream_reader_if
  import gbuff_pkg::*;
#(
  parameter int unsigned DATA_BITS = DATA_BITS_DEF
) ();

  logic                 m_valid;
  logic                 m_ready;
  logic [DATA_BITS-1:0] m_data;
  logic                 m_last;

  modport master (
    output m_valid,
    output m_data,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_last,
    output m_ready
  );

endinterface

// File: rtl/gbuff_rd_fifo.sv
// Two-entry synchronous FIFO holding {last, data} words returned by the buffer.
module gbuff_rd_fifo #(
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_pop  = pop && (count_q != 2'd0);
    do_push = push && ((count_q != 2'd2) || do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + 2'(do_push) - 2'(do_pop);
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/gbuff_stream_reader.sv
// Walks a contiguous global-buffer address range, one read per cycle, and
// returns the words on a valid/ready stream with the final word flagged.
module gbuff_stream_reader
  import gbuff_pkg::*;
#(
  parameter int unsigned ADDR_BITS = ADDR_BITS_DEF,
  parameter int unsigned DATA_BITS = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] base_addr,
  input  logic [ADDR_BITS:0]   length,
  output logic                 busy,
  output logic                 done,
  output logic                 gb_wr_en,
  output logic [ADDR_BITS-1:0] gb_index,
  input  logic [DATA_BITS-1:0] gb_data_out,
  gbuff_stream_reader_if.master m
);

  gbuff_state_e         state_q;
  logic [ADDR_BITS:0]   length_q;
  logic [ADDR_BITS:0]   issued_q;
  logic [ADDR_BITS-1:0] next_addr_q;
  logic                 inflight_q;
  logic                 inflight_last_q;

  logic [1:0]           fifo_count;
  logic [DATA_BITS:0]   fifo_head;
  logic                 pop;
  logic [2:0]           occ;
  logic                 issue;
  logic                 issue_last;
  logic [ADDR_BITS-1:0] issue_addr;

  // Occupancy projected past this edge; issuing only below 2 keeps the FIFO from overflowing.
  always_comb begin
    pop        = (fifo_count != 2'd0) && m.m_ready;
    occ        = {1'b0, fifo_count} + 3'(inflight_q) - 3'(pop);
    issue      = 1'b0;
    issue_last = 1'b0;
    issue_addr = next_addr_q;
    unique case (state_q)
      StIdle: begin
        issue      = start && (length != '0);
        issue_last = length == (ADDR_BITS+1)'(1);
        issue_addr = base_addr;
      end
      StRun: begin
        issue      = (issued_q < length_q) && (occ < 3'd2);
        issue_last = (issued_q + (ADDR_BITS+1)'(1)) == length_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      busy            <= 1'b0;
      done            <= 1'b0;
      gb_index        <= '0;
      next_addr_q     <= '0;
      length_q        <= '0;
      issued_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      done            <= 1'b0;
      inflight_q      <= issue;
      inflight_last_q <= issue && issue_last;
      if (issue) begin
        gb_index    <= issue_addr;
        next_addr_q <= issue_addr + ADDR_BITS'(1);
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (length == '0) begin
              done <= 1'b1;
            end else begin
              length_q <= length;
              issued_q <= (ADDR_BITS+1)'(1);
              busy     <= 1'b1;
              state_q  <= issue_last ? StDrain : StRun;
            end
          end
        end
        StRun: begin
          if (issue) begin
            issued_q <= issued_q + (ADDR_BITS+1)'(1);
            if (issue_last) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (pop && fifo_head[DATA_BITS]) begin
            state_q <= StIdle;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  gbuff_rd_fifo #(
    .WIDTH(DATA_BITS + 1)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (inflight_q),
    .pop  (pop),
    .wdata({inflight_last_q, gb_data_out}),
    .rdata(fifo_head),
    .count(fifo_count)
  );

  assign gb_wr_en  = 1'b0;
  assign m.m_valid = fifo_count != 2'd0;
  assign m.m_data  = fifo_head[DATA_BITS-1:0];
  assign m.m_last  = fifo_head[DATA_BITS];

endmodule

// File: tb/tb_gbuff_stream_reader.sv
// Randomized bench for gbuff_stream_reader against a transfer-level queue model.
module tb_gbuff_stream_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] base_addr = '0;
  logic [8:0] length = '0;
  logic       busy;
  logic       done;
  logic       gb_wr_en;
  logic [7:0] gb_index;
  logic [7:0] gb_data_out = '0;

  gbuff_stream_reader_if #(.DATA_BITS(8)) strm ();

  gbuff_stream_reader #(
    .ADDR_BITS(8),
    .DATA_BITS(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .gb_wr_en   (gb_wr_en),
    .gb_index   (gb_index),
    .gb_data_out(gb_data_out),
    .m          (strm)
  );

  always #5 clk = ~clk;

  // Global buffer: read data updates on the falling edge.
  logic [7:0] mem [256];
  always @(negedge clk) gb_data_out <= mem[gb_index];

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  int         cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transfer-level model: each accepted start enqueues its words; handshakes pop them.
  logic [8:0] exp_q[$];
  int         hs_cyc[$];
  int         hs_count = 0;
  logic       exp_busy = 1'b0;
  logic       exp_done = 1'b0;
  logic       rst_prev = 1'b0;
  logic       stall_prev = 1'b0;
  logic [7:0] prev_data = '0;
  logic       prev_last = 1'b0;
  logic [7:0] prev_idx = '0;
  logic       saw_wrap = 1'b0;

  always @(negedge clk) begin
    logic       hs;
    logic       busy_now;
    logic [8:0] e;
    hs = strm.m_valid && strm.m_ready;
    check_eq("gb_wr_en", gb_wr_en, 0);
    if (rst_prev) begin
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_gb_index", gb_index, 0);
      check_eq("rst_m_valid", strm.m_valid, 0);
      check_eq("rst_m_data", strm.m_data, 0);
      check_eq("rst_m_last", strm.m_last, 0);
    end else begin
      check_eq("busy", busy, exp_busy);
      check_eq("done", done, exp_done);
      if (stall_prev) begin
        check_eq("stall_valid", strm.m_valid, 1);
        check_eq("stall_data", strm.m_data, prev_data);
        check_eq("stall_last", strm.m_last, prev_last);
      end
      if (exp_q.size() == 0) check_eq("valid_idle", strm.m_valid, 0);
    end
    if (prev_idx == 8'hFF && gb_index == 8'h00) saw_wrap = 1'b1;
    prev_idx = gb_index;
    if (hs) begin
      hs_cyc.push_back(cyc);
      hs_count++;
    end
    if (rst) begin
      exp_q.delete();
      exp_busy   = 1'b0;
      exp_done   = 1'b0;
      rst_prev   = 1'b1;
      stall_prev = 1'b0;
    end else begin
      busy_now = exp_busy;
      rst_prev = 1'b0;
      exp_done = 1'b0;
      if (hs) begin
        if (exp_q.size() == 0) begin
          check_eq("hs_spurious", hs, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("m_data", strm.m_data, e[7:0]);
          check_eq("m_last", strm.m_last, e[8]);
          if (exp_q.size() == 0) begin
            exp_busy = 1'b0;
            exp_done = 1'b1;
          end
        end
      end
      if (start && !busy_now) begin
        if (length == 0) begin
          exp_done = 1'b1;
        end else begin
          for (int i = 0; i < int'(length); i++)
            exp_q.push_back({i == int'(length) - 1, mem[(int'(base_addr) + i) % 256]});
          exp_busy = 1'b1;
        end
      end
      stall_prev = strm.m_valid && !strm.m_ready;
      prev_data  = strm.m_data;
      prev_last  = strm.m_last;
    end
  end

  // 0: always ready, 1: fixed 1,0,0,1,0,1 pattern, 2: random 3/4 ready.
  int         ready_mode = 0;
  int         pat_idx = 0;
  logic [5:0] pat = 6'b101001;

  task automatic step();
    @(posedge clk);
    #1;
    case (ready_mode)
      0: strm.m_ready = 1'b1;
      1: begin
        strm.m_ready = pat[pat_idx];
        pat_idx      = (pat_idx + 1) % 6;
      end
      default: strm.m_ready = ($urandom_range(3) != 0);
    endcase
  endtask

  task automatic do_start(input logic [7:0] b, input logic [8:0] l, output int at_cyc);
    start     = 1'b1;
    base_addr = b;
    length    = l;
    at_cyc    = cyc;
    step();
    start     = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((exp_busy || exp_done) && n < budget) begin
      step();
      n++;
    end
    check_eq({tag, "_timeout"}, n < budget, 1);
    check_eq({tag, "_busy_end"}, busy, 0);
  endtask

  initial begin
    int         sc;
    int         hs0;
    int         n;
    logic [8:0] len;
    strm.m_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    step();
    step();
    rst = 1'b0;
    step();
    check_eq("reset_busy", busy, 0);
    check_eq("reset_valid", strm.m_valid, 0);
    check_eq("reset_index", gb_index, 0);

    // Full-rate read with exact cycle timing.
    ready_mode = 0;
    hs_cyc.delete();
    do_start(8'h10, 9'd4, sc);
    wait_idle("fullrate", 50);
    check_eq("fullrate_nwords", hs_cyc.size(), 4);
    for (int i = 0; i < 4 && i < hs_cyc.size(); i++)
      check_eq("fullrate_cycle", hs_cyc[i], sc + 2 + i);

    // Address wrap.
    saw_wrap = 1'b0;
    do_start(8'hFE, 9'd4, sc);
    wait_idle("wrap", 50);
    check_eq("wrap_index", saw_wrap, 1);

    // Backpressure pattern.
    ready_mode = 1;
    pat_idx    = 0;
    do_start(8'h33, 9'd6, sc);
    wait_idle("backpressure", 100);

    // Zero length.
    ready_mode = 0;
    do_start(8'h55, 9'd0, sc);
    wait_idle("zero_len", 10);

    // Full buffer with an ignored start mid-transfer.
    ready_mode = 2;
    do_start(8'h00, 9'd256, sc);
    repeat (20) step();
    do_start(8'h80, 9'd5, sc);
    wait_idle("full_buf", 2000);

    // Reset after three of eight words.
    ready_mode = 0;
    hs0 = hs_count;
    do_start(8'h20, 9'd8, sc);
    n = 0;
    while (hs_count - hs0 < 3 && n < 50) begin
      step();
      n++;
    end
    check_eq("midrst_reach3", n < 50, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check_eq("midrst_no_done", done, 0);
    hs_cyc.delete();
    do_start(8'h40, 9'd2, sc);
    wait_idle("after_rst", 50);
    check_eq("after_rst_nwords", hs_cyc.size(), 2);

    // Randomized transfers over random buffer contents.
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      ready_mode = $urandom_range(2);
      if ($urandom_range(9) == 0) len = 9'($urandom_range(256));
      else len = 9'($urandom_range(12));
      do_start(8'($urandom_range(255)), len, sc);
      if (len > 3 && $urandom_range(1) == 1) begin
        step();
        do_start(8'($urandom_range(255)), 9'($urandom_range(1, 20)), sc);
      end
      wait_idle("random", int'(len) * 8 + 40);
      repeat ($urandom_range(2)) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
